display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across the 8-digit common-anode display.
- Each scan slot selects one nibble of a 32-bit display word, presents it to the decoder, and drives the matching anode low.
- Display words are double-buffered: a new word takes effect only at a frame boundary, so a frame never shows a mix of two words (no tearing).
- Sits between the user datapath (which supplies words) and the decoder/display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range 2..2^20.
- N_DIGITS, 8, number of digits scanned; fixed at 8 for this board, fixed width 3-bit index.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- value_in  input  32  display word; nibble k (bits 4k+3:4k) is shown on digit k
- load  input  1  single-cycle strobe; captures value_in into the pending buffer
- digit_en  input  8  per-digit enable; 0 keeps that digit's anode high (dark)
- blank_lz  input  1  1 = blank leading zeros of the active word
- hex_digit  output  4  nibble for the shared decoder's binary input
- AN  output  8  anodes, active low, at most one bit low
- digit_idx  output  3  index of the digit currently driven
- frame_tick  output  1  one-cycle pulse on the wrap 7->0
- pending  output  1  1 while a loaded word waits for the frame boundary

Behaviour:
- Reset (async, immediate): prescaler=0, digit_idx=0, active word=0, pending buffer=0, pending=0, frame_tick=0, AN=8'hFF, hex_digit=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0. The slot tick is asserted when prescaler==REFRESH_DIV-1.
- On slot tick: digit_idx increments modulo 8.
- frame_tick=1 in the cycle following the tick where digit_idx goes 7->0. frame_tick is registered.
- Frame boundary = the slot tick where digit_idx==7.
- At the frame boundary, if pending=1: active word <= pending buffer and pending <= 0.
- load (not at boundary): pending buffer <= value_in, pending <= 1. A second load before the boundary overwrites the buffer; the last load wins.
- load in the same cycle as a frame boundary: active word <= value_in directly, and pending <= 0. value_in overrides any older pending word.
- Registered outputs, updated one cycle after digit_idx changes:
  - hex_digit = active[4*digit_idx+3 : 4*digit_idx]
  - AN = ~(8'b1 << digit_idx), unless the digit is blanked.
- A digit is blanked (AN=8'hFF for that slot) when:
  - digit_en[digit_idx]=0, or
  - blank_lz=1 and digit_idx>0 and every nibble from digit_idx up to 7 of the active word is 0.
- Digit 0 is never blanked by blank_lz, so value 0 shows a single "0".
- digit_en and blank_lz are sampled every slot, with no buffering.
- Reset mid-frame discards both the pending and the active word.
- Latency: load to visible on display is at most 8*REFRESH_DIV+1 cycles.

Test Plan:
- REFRESH_DIV=4, digit_en=FF, blank_lz=0, reset released -> AN sequence FE,FD,FB,...,7F, each held 4 cycles; frame_tick every 32 cycles; hex_digit=0 throughout.
- load value_in=32'h89ABCDEF mid-frame -> pending=1 until the boundary, then hex_digit sequence F,E,D,C,B,A,9,8 on digits 0..7; pending=0.
- Two loads (32'h11111111 then 32'h22222222) in the same frame -> only digits showing 2 appear; 1 is never displayed.
- load 32'h00000042 exactly on a boundary cycle with blank_lz=1 -> from the next frame only digits 0,1 are lit (hex_digit 2 then 4); AN=FF in slots 2..7.
- digit_en=8'h0F with word 32'h12345678 -> AN low only in slots 0..3; slots 4..7 show AN=FF.
- Assert reset during slot 5 with pending=1 -> AN=FF and digit_idx=0 immediately; pending=0; after release the display shows all zeros.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexes one shared hex-to-7-segment decoder across an 8-digit
//   common-anode display. The display word is double-buffered. A newly loaded
//   word is swapped in only at the frame boundary, so one frame never shows
//   digits from two different words.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   value_in   32-bit display word; nibble k is shown on digit k
//   load       single-cycle strobe; captures value_in into the pending buffer
//   digit_en   per-digit enable; a 0 bit keeps that digit's anode high
//   blank_lz   1 = blank leading zeros of the active word (digit 0 never blanked)
//   hex_digit  nibble for the shared decoder's binary input (registered)
//   AN         anodes, active low, at most one bit low (registered)
//   digit_idx  index of the digit currently being scanned
//   frame_tick one-cycle pulse in the cycle after the 7->0 wrap
//   pending    1 while a loaded word waits for the frame boundary
module display_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int N_DIGITS    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] value_in,
   input  logic        load,
   input  logic [7:0]  digit_en,
   input  logic        blank_lz,
   output logic [3:0]  hex_digit,
   output logic [7:0]  AN,
   output logic [2:0]  digit_idx,
   output logic        frame_tick,
   output logic        pending
);

   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0] prescaler;
   logic [31:0]   active;
   logic [31:0]   pend_buf;
   logic          slot_tick;
   logic          boundary;
   logic [4:0]    bit_base;
   logic [31:0]   upper;
   logic          blanked;

   assign slot_tick = (prescaler == PW'(REFRESH_DIV - 1));
   // The last slot of the frame ends here; the word swap happens on this edge.
   assign boundary  = slot_tick && (digit_idx == 3'(N_DIGITS - 1));
   assign bit_base  = {digit_idx, 2'b00};

   // Leading-zero test: every nibble from the current digit up to 7 is zero.
   assign upper   = active >> bit_base;
   assign blanked = !digit_en[digit_idx] ||
                    (blank_lz && (digit_idx != 3'd0) && (upper == 32'd0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler  <= '0;
         digit_idx  <= 3'd0;
         frame_tick <= 1'b0;
      end else begin
         prescaler  <= slot_tick ? '0 : prescaler + 1'b1;
         if (slot_tick) digit_idx <= digit_idx + 3'd1;
         frame_tick <= boundary;
      end
   end

   // Double buffer. A load on the boundary bypasses the pending buffer, so
   // the newest word wins over any older pending one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active   <= 32'd0;
         pend_buf <= 32'd0;
         pending  <= 1'b0;
      end else if (load && boundary) begin
         active   <= value_in;
         pending  <= 1'b0;
      end else begin
         if (boundary && pending) begin
            active  <= pend_buf;
            pending <= 1'b0;
         end
         if (load) begin
            pend_buf <= value_in;
            pending  <= 1'b1;
         end
      end
   end

   // Output stage samples digit_idx and active together. Both change on the
   // same edge at a boundary, so slot 0 of a new frame already uses the new word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_digit <= 4'd0;
         AN        <= 8'hFF;
      end else begin
         hex_digit <= active[bit_base +: 4];
         AN        <= blanked ? 8'hFF : ~(8'b1 << digit_idx);
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] value_in;
   logic        load;
   logic [7:0]  digit_en;
   logic        blank_lz;
   logic [3:0]  hex_digit;
   logic [7:0]  AN;
   logic [2:0]  digit_idx;
   logic        frame_tick;
   logic        pending;

   display_scan_ctrl #(.REFRESH_DIV(DIV), .N_DIGITS(8)) dut (
      .clk(clk), .reset(reset), .value_in(value_in), .load(load),
      .digit_en(digit_en), .blank_lz(blank_lz), .hex_digit(hex_digit),
      .AN(AN), .digit_idx(digit_idx), .frame_tick(frame_tick), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] an;
      logic [3:0] hex;
      logic [2:0] idx;
      logic       ft;
      logic       pend;
   } obs_t;

   obs_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   // reference state: cycles since reset release, active word, buffer
   int          m_cyc  = 0;
   logic [31:0] m_act  = 0;
   logic [31:0] m_buf  = 0;
   logic        m_pend = 0;

   task automatic model_edge();
      obs_t e;
      int   idx;
      logic bnd;
      logic allz;
      if (reset) return;
      idx  = (m_cyc / DIV) % 8;
      bnd  = (m_cyc % FRAME) == FRAME - 1;
      allz = 1'b1;
      for (int j = idx; j < 8; j++) if (m_act[j*4 +: 4] != 4'd0) allz = 1'b0;
      if (!digit_en[idx] || (blank_lz && idx > 0 && allz)) e.an = 8'hFF;
      else e.an = ~(8'b1 << idx);
      e.hex = m_act[idx*4 +: 4];
      e.ft  = bnd;
      if (load && bnd) begin
         m_act = value_in; m_pend = 1'b0;
      end else begin
         if (bnd && m_pend) begin m_act = m_buf; m_pend = 1'b0; end
         if (load) begin m_buf = value_in; m_pend = 1'b1; end
      end
      m_cyc++;
      e.idx  = 3'((m_cyc / DIV) % 8);
      e.pend = m_pend;
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      obs_t e;
      obs_t got;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         got = {AN, hex_digit, digit_idx, frame_tick, pending};
         vectors++;
         assert (got === e) else begin
            miscompares++;
            $error("FAIL sb cyc%0d observed an=%h hex=%h idx=%0d ft=%b pend=%b expected an=%h hex=%h idx=%0d ft=%b pend=%b",
                   m_cyc, got.an, got.hex, got.idx, got.ft, got.pend, e.an, e.hex, e.idx, e.ft, e.pend);
         end
      end
   endtask

   // advance to the first cycle whose outputs show slot 0 of a new frame
   task automatic align_frame();
      step();
      while (m_cyc % FRAME != 1) step();
   endtask

   // directed per-slot check of a whole frame; lit gives the expected lit digits
   task automatic frame_check(input logic [31:0] word, input logic [7:0] lit);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("an_slot%0d", k), {24'd0, AN}, {24'd0, lit[k] ? ~(8'b1 << k) : 8'hFF});
         chk($sformatf("hex_slot%0d", k), {28'd0, hex_digit}, {28'd0, word[k*4 +: 4]});
         repeat (DIV) step();
      end
   endtask

   initial begin
      reset = 1'b1; value_in = '0; load = 1'b0; digit_en = 8'hFF; blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_an", {24'd0, AN}, 32'hFF);
      chk("rst_hex", {28'd0, hex_digit}, 32'd0);
      chk("rst_idx", {29'd0, digit_idx}, 32'd0);
      chk("rst_ft", {31'd0, frame_tick}, 32'd0);
      chk("rst_pend", {31'd0, pending}, 32'd0);
      reset = 1'b0;

      // free-running scan of an all-zero word
      step();
      frame_check(32'h0, 8'hFF);

      // mid-frame load waits for the boundary
      repeat (5) step();
      value_in = 32'h89ABCDEF; load = 1'b1; step(); load = 1'b0;
      chk("pend_after_load", {31'd0, pending}, 32'd1);
      align_frame();
      chk("pend_cleared", {31'd0, pending}, 32'd0);
      frame_check(32'h89ABCDEF, 8'hFF);

      // two loads in one frame: last one wins
      repeat (3) step();
      value_in = 32'h11111111; load = 1'b1; step(); load = 1'b0;
      repeat (4) step();
      value_in = 32'h22222222; load = 1'b1; step(); load = 1'b0;
      align_frame();
      frame_check(32'h22222222, 8'hFF);

      // load exactly on the boundary with leading-zero blanking
      blank_lz = 1'b1;
      while (m_cyc % FRAME != FRAME - 1) step();
      value_in = 32'h00000042; load = 1'b1; step(); load = 1'b0;
      chk("pend_bnd_load", {31'd0, pending}, 32'd0);
      step();
      frame_check(32'h00000042, 8'h03);

      // per-digit enables
      blank_lz = 1'b0; digit_en = 8'h0F;
      repeat (2) step();
      value_in = 32'h12345678; load = 1'b1; step(); load = 1'b0;
      align_frame();
      frame_check(32'h12345678, 8'h0F);

      // reset during slot 5 with a word pending
      digit_en = 8'hFF;
      step();
      while (m_cyc % FRAME != 18) step();
      value_in = 32'hAAAAAAAA; load = 1'b1; step(); load = 1'b0;
      while (m_cyc % FRAME != 21) step();
      chk("idx_slot5", {29'd0, digit_idx}, 32'd5);
      chk("pend_slot5", {31'd0, pending}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_an", {24'd0, AN}, 32'hFF);
      chk("mid_rst_idx", {29'd0, digit_idx}, 32'd0);
      chk("mid_rst_pend", {31'd0, pending}, 32'd0);
      chk("mid_rst_hex", {28'd0, hex_digit}, 32'd0);
      m_cyc = 0; m_act = '0; m_buf = '0; m_pend = 1'b0;
      sb.delete();
      repeat (3) step();
      reset = 1'b0;
      step();
      frame_check(32'h0, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
